// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Instruction prefetch FIFO between the fetch stage and the
//               IF/ID pipeline register. Each entry carries the fetched
//               instruction word and its PC+4. A taken branch (flush) empties
//               the queue; an ID-stage stall (freeze) holds the head entry
//               while fetch keeps filling the queue.
//               Optional build macro IFQ_BYPASS_EN adds a zero-latency path
//               from in_* to out_* when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_pc,
  input  logic [W-1:0]  in_instr,
  input  logic          flush,
  input  logic          freeze,
  output logic          out_valid,
  output logic [W-1:0]  out_pc,
  output logic [W-1:0]  out_instr,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_EMPTY = '0;
  localparam logic [AW-1:0] C_ONE   = AW'(1);

  // Pointer and occupancy state
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q,  count_d;

  // Storage; contents are meaningless until written, so no reset
  logic [W-1:0] pc_mem_q    [DEPTH];
  logic [W-1:0] instr_mem_q [DEPTH];

  logic empty;
  logic bypass;
  logic pop;
  logic pop_mem;
  logic push;

  // Handshake, head presentation and push/pop qualification
  always_comb begin
    empty     = (count_q == C_EMPTY);
    in_ready  = (count_q != C_FULL);
`ifdef IFQ_BYPASS_EN
    bypass    = empty & in_valid & ~flush;
`else
    bypass    = 1'b0;
`endif
    out_valid = ~empty | bypass;
    out_pc    = '0;
    out_instr = '0;
    if (!empty) begin
      out_pc    = pc_mem_q[rd_ptr_q];
      out_instr = instr_mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
    pop     = out_valid & ~freeze & ~flush;
    // A bypassed entry consumed the same cycle never touches storage
    pop_mem = pop & ~empty;
    push    = in_valid & in_ready & ~flush & ~(bypass & pop);
    count   = count_q;
  end

  // Next-state for pointers and occupancy; flush overrides everything
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push)    wr_ptr_d = wr_ptr_q + C_ONE;
      if (pop_mem) rd_ptr_d = rd_ptr_q + C_ONE;
      case ({push, pop_mem})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write at the tail on every accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_queue
// Description : Directed self-checking bench for if_fetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        freeze = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  if_fetch_queue #(.DEPTH(4), .AW(2), .W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fz, input logic fl);
    in_valid = v;
    in_pc    = pc;
    in_instr = ins;
    freeze   = fz;
    flush    = fl;
    #1;
  endtask

  logic [31:0] instr_tab [4];

  initial begin
    instr_tab[0] = 32'hE3A01A01;
    instr_tab[1] = 32'hE3A00B01;
    instr_tab[2] = 32'hE4801000;
    instr_tab[3] = 32'hE490B000;

    // Reset held with fetch presenting data
    drive(1'b1, 32'd100, 32'hDEADBEEF, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_count", {29'd0, count}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_count2", {29'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Fill under freeze
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * (i + 1)), instr_tab[i], 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("fill_count", {29'd0, count}, 32'd4);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    chk("fill_head_pc", out_pc, 32'd4);
    chk("fill_head_instr", out_instr, 32'hE3A01A01);

    // Drain in order
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, 32'(4 * (i + 1)));
      chk("drain_instr", out_instr, instr_tab[i]);
      tick();
    end
    chk("drain_count", {29'd0, count}, 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_out_pc", out_pc, 32'd0);

    // Steady occupancy of 2 with push+pop every cycle across pointer wrap
    drive(1'b1, 32'h100, ~32'h100, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h104, ~32'h104, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h108 + 32'(4 * i), ~(32'h108 + 32'(4 * i)), 1'b0, 1'b0);
      chk("wrap_pc", out_pc, 32'h100 + 32'(4 * i));
      chk("wrap_instr", out_instr, ~(32'h100 + 32'(4 * i)));
      tick();
      chk("wrap_count", {29'd0, count}, 32'd2);
    end
    chk("wrap_head_after", out_pc, 32'h128);

    // Fill to full; push while full and frozen is ignored
    drive(1'b1, 32'h130, 32'h0130, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h134, 32'h0134, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h138, 32'h0138, 1'b1, 1'b0);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("full_ignored_count", {29'd0, count}, 32'd4);
    chk("full_ignored_head", out_pc, 32'h128);

    // Full with pop: no passthrough, pop happens, push on the next edge
    drive(1'b1, 32'h138, 32'h0138, 1'b0, 1'b0);
    chk("fullpop_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("fullpop_count", {29'd0, count}, 32'd3);
    chk("fullpop_head", out_pc, 32'h12C);
    drive(1'b1, 32'h138, 32'h0138, 1'b1, 1'b0);
    chk("fullpop_in_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    chk("fullpop_accept_count", {29'd0, count}, 32'd4);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("pre_flush_count", {29'd0, count}, 32'd3);
    chk("pre_flush_head", out_pc, 32'h130);

    // Flush beats freeze and drops the same-cycle push
    drive(1'b1, 32'd20, 32'h14, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("flush_count", {29'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_pc", out_pc, 32'd0);
    tick();
    chk("flush_no_20_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_no_20_pc", out_pc, 32'd0);

    // Empty queue, single push with no freeze
    drive(1'b1, 32'd24, 32'h18, 1'b0, 1'b0);
`ifdef IFQ_BYPASS_EN
    chk("byp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("byp_out_pc", out_pc, 32'd24);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("byp_count", {29'd0, count}, 32'd0);
    chk("byp_after_valid", {31'd0, out_valid}, 32'd0);
`else
    chk("nobyp_out_valid", {31'd0, out_valid}, 32'd0);
    chk("nobyp_out_pc", out_pc, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("nobyp_count", {29'd0, count}, 32'd1);
    chk("nobyp_pc_late", out_pc, 32'd24);
    chk("nobyp_instr_late", out_instr, 32'h18);
    tick();
    chk("nobyp_drained", {29'd0, count}, 32'd0);
`endif

    // Asynchronous reset mid-operation
    drive(1'b1, 32'd40, 32'h28, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'd44, 32'h2C, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("pre_arst_count", {29'd0, count}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_pc", out_pc, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against any stall in the directed sequence
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Small instruction prefetch FIFO between the instruction fetch stage and the IF/ID pipeline register.
- Decouples fetch from ID-stage stalls: fetch keeps filling the queue while ID is frozen by the hazard unit.
- A branch taken in the downstream stages flushes every queued instruction.
- Each entry holds the fetched instruction word and its PC+4 value, matching the fetch stage's PC output convention.

Parameters:
- DEPTH, 4: number of entries; power of two, >= 2.
- AW, 2: pointer width; must equal log2(DEPTH).
- W, 32: width of the PC and instruction fields.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  fetch stage presents a fetched instruction.
- in_ready  output  1  queue can accept a push this cycle.
- in_pc  input  W  PC+4 of the fetched instruction.
- in_instr  input  W  fetched instruction word.
- flush  input  1  branch taken; discard all queued and incoming entries.
- freeze  input  1  ID stage stalled; do not pop.
- out_valid  output  1  head entry is valid.
- out_pc  output  W  head PC+4 value; 0 when out_valid=0.
- out_instr  output  W  head instruction; 0 when out_valid=0.
- count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, out_pc=0, out_instr=0, in_ready=1. Storage contents are don't-care.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & ~freeze & ~flush.
- in_ready = (count != DEPTH). It is combinational from count only. There is no full-and-pop passthrough: when full, in_ready=0 even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_pc and out_instr are read combinationally from the rd_ptr entry and gated to 0 when empty.
- Latency: an entry pushed at edge N appears on the outputs after edge N when the queue was empty. Otherwise it appears in FIFO order.
- Push only: write entry at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance; count is unchanged. This is legal at any occupancy 1..DEPTH-1.
- Pointer wrap: pointers increment modulo DEPTH (natural AW-bit overflow). Entry DEPTH-1 is followed by entry 0.
- Flush: at the next edge rd_ptr=wr_ptr=0 and count=0.
  - Any same-cycle push is dropped.
  - No pop is counted.
  - flush has priority over freeze.
- freeze with the queue non-empty: outputs hold their current values and the head is not consumed. Pushes continue until the queue is full.
- freeze with the queue empty: no effect.
- Push attempted while full (in_valid=1, in_ready=0): ignored, no state change. The fetch stage is responsible for holding its PC, since its freeze input is driven by ~in_ready.
- No other state machine; all state is the pointers, count and the storage array.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- With the macro defined:
  - When count==0, in_valid=1 and flush=0, the outputs present in_pc/in_instr combinationally with out_valid=1 (zero-latency bypass).
  - If pop also holds (freeze=0), the entry is consumed directly and not written into storage; count stays 0.
  - If freeze=1, the entry is written normally (count becomes 1).
- Without the macro: no combinational path from the in_* inputs to the out_* outputs. Minimum latency is 1 cycle as described above.

Test Plan:
- Reset: hold rst=0, apply in_valid=1 with clocks running, then release rst -> out_valid=0, out_pc=0, count=0, in_ready=1.
- Fill/drain under freeze: freeze=1, push pc=4/8/12/16 with instr 32'hE3A01A01, E3A00B01, E4801000, E490B000 -> after 4 edges count=4, in_ready=0, head pc=4. Then freeze=0 -> pops in order 4, 8, 12, 16, with one edge between each; count ends at 0.
- Wrap-around with simultaneous push/pop: keep count=2 while pushing and popping every cycle for 10 cycles -> count stays 2; the output pc sequence is strictly +4 with no gaps or duplicates across pointer wrap.
- Full with pop: count=4, in_valid=1, freeze=0 -> in_ready=0, pop occurs, count=3 next cycle; the incoming entry is accepted on the following edge.
- Flush: count=3, in_valid=1 (pc=20), flush=1, freeze=1 -> next cycle count=0, out_valid=0, and pc=20 never appears at the output.
- Bypass (IFQ_BYPASS_EN defined): empty queue, in_valid=1, pc=24, freeze=0 -> out_valid=1 and out_pc=24 in the same cycle; count remains 0 after the edge. Without the macro: out_pc=24 appears one cycle later.
